valve_sequencer: RTL and testbench
==================================

// Module: valve_sequencer
// PURPOSE
// - Drives the air_in control lines of a bank of valve instances with a phase pattern table.
// - Typical uses are peristaltic pumping (3 valves, 6 phases) and timed mixer/chamber isolation.
// - Sits between the host/config logic and the valve primitives; air_out[i] feeds valve i.
// - Pressurised line (1) = valve closed. All-ones is the SAFE state.
// PARAMETERS
// - N_VALVES  3   number of valve air lines driven
// - N_PHASES  6   pattern table depth (phases per cycle), >=2
// - DWELL_W   16  width of per-phase dwell count (clock cycles)
// - CYCLE_W   8   width of repeat count
// PORTS
// - clk          in   1                   single clock, all logic rising-edge
// - rst          in   1                   synchronous, active-high reset
// - cfg_we       in   1                   write pattern table entry cfg_addr
// - cfg_addr     in   $clog2(N_PHASES)    phase index to write; >=N_PHASES ignored
// - cfg_pattern  in   N_VALVES            air_out value for that phase
// - cfg_dwell    in   DWELL_W             cycles to hold that phase; 0 treated as 1
// - n_cycles     in   CYCLE_W             full table passes to run, sampled at start; 0 = run until stop
// - start        in   1                   begin sequence (level, acted on in IDLE only)
// - stop         in   1                   abort; has priority over start
// - air_out      out  N_VALVES            registered valve air drive
// - busy         out  1                   sequence running
// - done         out  1                   1-cycle pulse on normal completion
// - phase_idx    out  $clog2(N_PHASES)    current phase
// - cycles_left  out  CYCLE_W             remaining passes incl. current
// BEHAVIOUR
// - Reset values:
//   - air_out = all ones; busy = 0; done = 0; phase_idx = 0; cycles_left = 0.
//   - Table entries: pattern all ones, dwell 1.
// - FSM states IDLE, RUN, DONE. All outputs are registered.
// - IDLE:
//   - air_out = SAFE.
//   - cfg_we writes the table.
//   - start & !stop -> RUN next edge; at that edge busy = 1, phase_idx = 0, air_out = pattern[0], dwell counter loaded.
//   - Latency start->air_out is 1 cycle.
// - RUN:
//   - Each phase holds air_out for exactly max(dwell,1) cycles.
//   - Then phase_idx+1, air_out = pattern[next], dwell counter reloaded.
//   - Wrap: after phase N_PHASES-1:
//     - cycles_left decrements.
//     - If it reaches 0 (and n_cycles != 0) -> DONE; otherwise phase 0.
//   - n_cycles = 0: cycles_left stays 0 and the sequence loops indefinitely.
//   - cfg_we is ignored while busy (the table is locked).
//   - start is ignored while busy.
// - DONE (1 cycle): done = 1, busy = 0, air_out = SAFE, then IDLE.
// - stop in RUN: next edge air_out = SAFE, busy = 0, IDLE; done is not pulsed.
// - stop and a phase boundary on the same edge: stop wins.
// - rst mid-run: all state is back at reset values on the next edge, the table included.
// CONFIGURATION
// - Macro: VALVE_SEQ_BREAK_BEFORE_MAKE_EN.
// - Defined:
//   - At each phase change, one extra cycle drives air_out = old | new (close before open).
//   - The new pattern's dwell count starts after that cycle.
//   - No extra cycle is inserted if old == new.
//   - Transitions into and out of SAFE need no extra cycle.
// - Undefined: air_out switches directly old -> new; phase period = dwell exactly.
// TESTING
// - Reset: rst=1 for 2 cycles -> air_out=3'b111, busy=0, done=0, phase_idx=0.
// - Pump run:
//   - Setup: table {110,100,101,001,011,010}, dwell 4 each, n_cycles=2, start pulse at T.
//   - Required response:
//     - air_out=110 at T+1..T+4, then 100 at T+5.
//     - done pulses at T+49, busy low from T+49.
// - Dwell 0:
//   - Setup: entry 2 dwell=0, n_cycles=1.
//   - Required response: phase 2 is held exactly 1 cycle.
// - Stop priority:
//   - Stimulus: stop asserted in the same cycle as the phase 3->4 boundary.
//   - Required response: air_out=111 next cycle, busy=0, done never pulses.
// - Lock:
//   - Stimulus: cfg_we addr 0 pattern 000 while busy.
//   - Required response: the next pass still shows 110 in phase 0.
// - BREAK_BEFORE_MAKE_EN:
//   - Stimulus: 110->100 with dwell 4.
//   - Required response: air_out 110 x4, 110 x1, 100 x4.
//   - Continuous mode (n_cycles=0) runs more than 3 passes until stop.

Source files
------------

// File: rtl/valve_sequencer.sv
// valve_sequencer: plays a phase pattern table onto a bank of valve air lines.
// Each phase holds its pattern for max(dwell,1) cycles. The table runs n_cycles
// passes, or loops until stop when n_cycles is 0. All-ones on air_out is the
// safe state, with every valve closed.
// Optional feature: define VALVE_SEQ_BREAK_BEFORE_MAKE_EN to insert one
// old|new overlap cycle at each in-run phase change where the pattern differs.
module valve_sequencer #(
   parameter int unsigned N_VALVES = 3,
   parameter int unsigned N_PHASES = 6,
   parameter int unsigned DWELL_W  = 16,
   parameter int unsigned CYCLE_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [$clog2(N_PHASES)-1:0]   cfg_addr,
   input  logic [N_VALVES-1:0]           cfg_pattern,
   input  logic [DWELL_W-1:0]            cfg_dwell,
   input  logic [CYCLE_W-1:0]            n_cycles,
   input  logic                          start,
   input  logic                          stop,
   output logic [N_VALVES-1:0]           air_out,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(N_PHASES)-1:0]   phase_idx,
   output logic [CYCLE_W-1:0]            cycles_left
);

   localparam int unsigned PH_W = $clog2(N_PHASES);
   localparam logic [N_VALVES-1:0] SAFE = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [N_VALVES-1:0]   pat_q   [N_PHASES];
   logic [DWELL_W-1:0]    dwell_q [N_PHASES];
   logic [DWELL_W-1:0]    cnt_q, cnt_d;
   logic                  bbm_q, bbm_d;
   logic [N_VALVES-1:0]   air_d;
   logic                  busy_d, done_d;
   logic [PH_W-1:0]       phase_d, nxt_phase;
   logic [CYCLE_W-1:0]    cyc_d;
   logic                  phase_last;
   logic                  tbl_we;

   // Remaining-cycle counter value for a phase: a dwell of 0 behaves as 1.
   function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - DWELL_W'(1);
   endfunction

   // Pattern table; written only while no sequence is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(N_PHASES); i++) begin
            pat_q[i]   <= SAFE;
            dwell_q[i] <= DWELL_W'(1);
         end
      end else if (tbl_we) begin
         pat_q[cfg_addr]   <= cfg_pattern;
         dwell_q[cfg_addr] <= cfg_dwell;
      end
   end

   // State, dwell counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bbm_q       <= 1'b0;
         air_out     <= SAFE;
         busy        <= 1'b0;
         done        <= 1'b0;
         phase_idx   <= '0;
         cycles_left <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bbm_q       <= bbm_d;
         air_out     <= air_d;
         busy        <= busy_d;
         done        <= done_d;
         phase_idx   <= phase_d;
         cycles_left <= cyc_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bbm_d      = 1'b0;
      air_d      = air_out;
      busy_d     = busy;
      done_d     = 1'b0;
      phase_d    = phase_idx;
      cyc_d      = cycles_left;
      tbl_we     = 1'b0;
      phase_last = (phase_idx == PH_W'(N_PHASES - 1));
      nxt_phase  = phase_last ? '0 : phase_idx + PH_W'(1);

      case (state_q)
         S_IDLE: begin
            air_d  = SAFE;
            busy_d = 1'b0;
            if (cfg_we && (32'(cfg_addr) < N_PHASES)) begin
               tbl_we = 1'b1;
            end
            if (start && !stop) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               phase_d = '0;
               air_d   = pat_q[0];
               cnt_d   = dwell_load(dwell_q[0]);
               cyc_d   = n_cycles;
            end
         end

         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               air_d   = SAFE;
               busy_d  = 1'b0;
               phase_d = '0;
               cyc_d   = '0;
            end else if (bbm_q) begin
               // Overlap cycle finished: open to the new pattern, dwell starts now.
               air_d = pat_q[phase_idx];
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (phase_last && (cycles_left == CYCLE_W'(1))) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               air_d   = SAFE;
               phase_d = '0;
               cyc_d   = '0;
            end else begin
               if (phase_last && (cycles_left != '0)) begin
                  cyc_d = cycles_left - CYCLE_W'(1);
               end
               phase_d = nxt_phase;
               cnt_d   = dwell_load(dwell_q[nxt_phase]);
`ifdef VALVE_SEQ_BREAK_BEFORE_MAKE_EN
               if (pat_q[nxt_phase] != air_out) begin
                  air_d = air_out | pat_q[nxt_phase];
                  bbm_d = 1'b1;
               end else begin
                  air_d = pat_q[nxt_phase];
               end
`else
               air_d = pat_q[nxt_phase];
`endif
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            air_d   = SAFE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            air_d   = SAFE;
            busy_d  = 1'b0;
            phase_d = '0;
            cyc_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// Testbench for valve_sequencer (default build): expected cycle-by-cycle traces
// are expanded from the table contents into a queue and compared each cycle.
module tb_valve_sequencer;

   localparam int unsigned NV = 3;
   localparam int unsigned NP = 6;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;
   localparam int unsigned PW = $clog2(NP);

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [PW-1:0] cfg_addr;
   logic [NV-1:0] cfg_pattern;
   logic [DW-1:0] cfg_dwell;
   logic [CW-1:0] n_cycles;
   logic          start;
   logic          stop;
   logic [NV-1:0] air_out;
   logic          busy;
   logic          done;
   logic [PW-1:0] phase_idx;
   logic [CW-1:0] cycles_left;

   valve_sequencer #(.N_VALVES(NV), .N_PHASES(NP), .DWELL_W(DW), .CYCLE_W(CW)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_pattern(cfg_pattern), .cfg_dwell(cfg_dwell), .n_cycles(n_cycles),
      .start(start), .stop(stop), .air_out(air_out), .busy(busy), .done(done),
      .phase_idx(phase_idx), .cycles_left(cycles_left)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NV-1:0] air;
      logic          busy;
      logic          done;
      logic [PW-1:0] ph;
      logic [CW-1:0] cyc;
   } obs_t;

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   logic [NV-1:0] m_pat [NP];
   int            m_dw  [NP];
   obs_t          exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic obs_t idle_o();
      obs_t o;
      o     = '0;
      o.air = '1;
      return o;
   endfunction

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic cmp(input string tag, input obs_t e);
      check({tag, ".air"},   32'(air_out),     32'(e.air));
      check({tag, ".busy"},  32'(busy),        32'(e.busy));
      check({tag, ".done"},  32'(done),        32'(e.done));
      check({tag, ".phase"}, 32'(phase_idx),   32'(e.ph));
      check({tag, ".cyc"},   32'(cycles_left), 32'(e.cyc));
   endtask

   task automatic cyc_begin();
      @(posedge clk);
      #1;
   endtask

   // Expand the model table into the expected per-cycle trace after start.
   task automatic build(input int n, input int cont_passes);
      obs_t o;
      int np;
      exp_q.delete();
      np = (n == 0) ? cont_passes : n;
      for (int pass = 0; pass < np; pass++)
         for (int p = 0; p < int'(NP); p++)
            for (int k = 0; k < eff(m_dw[p]); k++) begin
               o.air  = m_pat[p];
               o.busy = 1'b1;
               o.done = 1'b0;
               o.ph   = PW'(p);
               o.cyc  = (n == 0) ? '0 : CW'(n - pass);
               exp_q.push_back(o);
            end
      if (n != 0) begin
         o      = idle_o();
         o.done = 1'b1;
         exp_q.push_back(o);
      end
   endtask

   task automatic write(input int addr, input logic [NV-1:0] pat, input int dw);
      cyc_begin();
      cfg_we      = 1'b1;
      cfg_addr    = PW'(addr);
      cfg_pattern = pat;
      cfg_dwell   = DW'(dw);
      if (addr < int'(NP)) begin
         m_pat[addr] = pat;
         m_dw[addr]  = dw;
      end
      cyc_begin();
      cfg_we = 1'b0;
   endtask

   // Start a run and compare each cycle; stop_at>0 raises stop while trace entry
   // stop_at-1 is shown; lock_at>=0 attempts a table write during that entry.
   task automatic run_seq(input string tag, input int n, input int stop_at, input int lock_at);
      cyc_begin();
      n_cycles = CW'(n);
      start    = 1'b1;
      @(negedge clk);
      cmp({tag, ".pre"}, idle_o());
      for (int i = 0; i < exp_q.size(); i++) begin
         cyc_begin();
         start       = 1'b0;
         stop        = (i == stop_at - 1);
         cfg_we      = (i == lock_at);
         cfg_addr    = '0;
         cfg_pattern = '0;
         cfg_dwell   = DW'(9);
         @(negedge clk);
         cmp($sformatf("%s.t%0d", tag, i + 1), exp_q[i]);
         if (stop) break;
      end
      for (int i = 0; i < 3; i++) begin
         cyc_begin();
         stop   = 1'b0;
         cfg_we = 1'b0;
         @(negedge clk);
         cmp($sformatf("%s.post%0d", tag, i), idle_o());
      end
   endtask

   task automatic load_pump();
      logic [NV-1:0] pump [NP];
      pump = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
      for (int p = 0; p < int'(NP); p++) write(p, pump[p], 4);
   endtask

   initial begin
      int sp, nn, st;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_dwell = '0;
      n_cycles = '0; start = 1'b0; stop = 1'b0;
      for (int p = 0; p < int'(NP); p++) begin m_pat[p] = '1; m_dw[p] = 1; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp("reset", idle_o());
      cyc_begin();
      rst = 1'b0;

      // Pump: two passes, dwell 4, done at T+49.
      load_pump();
      build(2, 0);
      run_seq("pump", 2, 0, -1);

      // Dwell 0 on entry 2, single pass.
      write(2, 3'b101, 0);
      build(1, 0);
      run_seq("dwell0", 1, 0, -1);
      write(2, 3'b101, 4);

      // Table write while busy is ignored.
      build(2, 0);
      run_seq("lock", 2, 0, 2);

      // Stop coinciding with the phase 3->4 boundary.
      sp = 0;
      for (int p = 0; p <= 3; p++) sp += eff(m_dw[p]);
      build(2, 0);
      run_seq("stopb", 2, sp, -1);

      // Continuous mode: four passes then stop.
      for (int p = 0; p < int'(NP); p++) write(p, m_pat[p], 2);
      build(0, 4);
      run_seq("cont", 0, exp_q.size(), -1);

      // Random tables, dwells, pass counts and stops.
      for (int it = 0; it < 8; it++) begin
         for (int p = 0; p < int'(NP); p++)
            write(p, NV'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
         write(int'($urandom_range(6, 7)), NV'($urandom_range(0, 7)), 3);
         nn = int'($urandom_range(0, 3));
         build(nn, 2);
         st = ($urandom_range(0, 1) == 1 || nn == 0) ? int'($urandom_range(1, exp_q.size())) : 0;
         run_seq($sformatf("rnd%0d", it), nn, st, -1);
      end

      // Reset mid-run restores outputs and the table.
      cyc_begin();
      n_cycles = CW'(3);
      start    = 1'b1;
      repeat (5) begin
         cyc_begin();
         start = 1'b0;
      end
      cyc_begin();
      rst = 1'b1;
      cyc_begin();
      rst = 1'b0;
      @(negedge clk);
      cmp("midrst", idle_o());
      for (int p = 0; p < int'(NP); p++) begin m_pat[p] = '1; m_dw[p] = 1; end
      build(1, 0);
      run_seq("aftrst", 1, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
